// File: rtl/usb_bus_turnaround.sv
// usb_bus_turnaround
//
// Direction controller for the USB D+/D- pair. It sits between the USB
// transmit/receive logic and the bidirectional pins and sequences bus
// ownership: the transmitter requests the bus, waits for a qualified idle (J)
// guard period, drives its data, then drives J for a hold period. The pins
// are then released and the receive path is blanked for a turnaround window
// so the transmitter's own tail is never presented as received data.
//
// Parameters
//   GUARD_CYCLES  consecutive synchronised idle-J samples before grant (1..255)
//   HOLD_CYCLES   cycles J is driven after tx_req drops (1..255)
//   TURN_CYCLES   cycles the receive path stays blanked after release (1..255)
//   LOW_SPEED     0: J is D+=1/D-=0 (full speed); 1: J is D+=0/D-=1 (low speed)
//   SYNC_STAGES   receive synchroniser depth (2..4)
//
// Ports
//   clk         system clock
//   n_rst       asynchronous active-low reset
//   tx_req      bus ownership request, held for the whole packet incl. EOP
//   tx_d_plus   D+ level to drive while granted
//   tx_d_minus  D- level to drive while granted
//   tx_grant    registered; high only while data is being driven
//   busy        registered; high whenever not idle in receive
//   rx_d_plus   synchronised D+ to the receiver, J while blanked
//   rx_d_minus  synchronised D- to the receiver, J while blanked
//   rx_valid    registered; high only when idle in receive
//   d_plus      D+ pin, driven only during drive/hold, otherwise high-Z
//   d_minus     D- pin, driven only during drive/hold, otherwise high-Z

module usb_bus_turnaround #(
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES  = 8,
    parameter int unsigned TURN_CYCLES  = 16,
    parameter bit          LOW_SPEED    = 1'b0,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic tx_req,
    input  logic tx_d_plus,
    input  logic tx_d_minus,
    output logic tx_grant,
    output logic busy,
    output logic rx_d_plus,
    output logic rx_d_minus,
    output logic rx_valid,
    inout  logic d_plus,
    inout  logic d_minus
);

    // Idle (J) line levels for the selected speed.
    localparam logic J_PLUS  = LOW_SPEED ? 1'b0 : 1'b1;
    localparam logic J_MINUS = LOW_SPEED ? 1'b1 : 1'b0;

    // Counter reload values; the 8-bit counter only ever counts down from a load.
    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] TURN_LOAD  = 8'(TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        TX_WAIT,
        TX_DRIVE,
        TX_HOLD_J,
        TURNAROUND
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] count;
    logic [7:0] count_next;

    logic [SYNC_STAGES-1:0] sync_plus;
    logic [SYNC_STAGES-1:0] sync_minus;
    logic                   line_plus;
    logic                   line_minus;
    logic                   line_idle;

    logic drive_en;
    logic drive_plus;
    logic drive_minus;

    // ------------------------------------------------------------------
    // Receive synchroniser: free-running in every state, reset to J so the
    // receiver sees an idle line straight out of reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_plus  <= {SYNC_STAGES{J_PLUS}};
            sync_minus <= {SYNC_STAGES{J_MINUS}};
        end else begin
            sync_plus  <= {sync_plus[SYNC_STAGES-2:0], d_plus};
            sync_minus <= {sync_minus[SYNC_STAGES-2:0], d_minus};
        end
    end

    assign line_plus  = sync_plus[SYNC_STAGES-1];
    assign line_minus = sync_minus[SYNC_STAGES-1];
    assign line_idle  = (line_plus == J_PLUS) && (line_minus == J_MINUS);

    // ------------------------------------------------------------------
    // State and counter registers. The status flags are registered from the
    // next state so they line up exactly with the state they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= RX_IDLE;
            count    <= '0;
            tx_grant <= 1'b0;
            busy     <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            tx_grant <= (state_next == TX_DRIVE);
            busy     <= (state_next != RX_IDLE);
            rx_valid <= (state_next == RX_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            RX_IDLE: begin
                if (tx_req) begin
                    state_next = TX_WAIT;
                    count_next = GUARD_LOAD;
                end
            end
            TX_WAIT: begin
                // Abort wins over grant; any non-J sample restarts the guard.
                if (!tx_req) begin
                    state_next = RX_IDLE;
                end else if (!line_idle) begin
                    count_next = GUARD_LOAD;
                end else if (count == 8'd0) begin
                    state_next = TX_DRIVE;
                end else begin
                    count_next = count - 8'd1;
                end
            end
            TX_DRIVE: begin
                if (!tx_req) begin
                    state_next = TX_HOLD_J;
                    count_next = HOLD_LOAD;
                end
            end
            TX_HOLD_J: begin
                if (count == 8'd0) begin
                    state_next = TURNAROUND;
                    count_next = TURN_LOAD;
                end else begin
                    count_next = count - 8'd1;
                end
            end
            TURNAROUND: begin
                if (count == 8'd0) begin
                    state_next = RX_IDLE;
                end else begin
                    count_next = count - 8'd1;
                end
            end
            default: begin
                state_next = RX_IDLE;
                count_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pin drive. The enable comes only from the registered state, so an
    // asynchronous reset releases the pins immediately.
    // ------------------------------------------------------------------
    always_comb begin
        drive_en    = 1'b0;
        drive_plus  = J_PLUS;
        drive_minus = J_MINUS;
        if (state == TX_DRIVE) begin
            drive_en    = 1'b1;
            drive_plus  = tx_d_plus;
            drive_minus = tx_d_minus;
        end else if (state == TX_HOLD_J) begin
            drive_en    = 1'b1;
        end
    end

    assign d_plus  = drive_en ? drive_plus  : 1'bz;
    assign d_minus = drive_en ? drive_minus : 1'bz;

    // Receive path: live synchronised lines only when idle in receive,
    // otherwise held at J so the receiver never sees our own traffic.
    always_comb begin
        rx_d_plus  = J_PLUS;
        rx_d_minus = J_MINUS;
        if (state == RX_IDLE) begin
            rx_d_plus  = line_plus;
            rx_d_minus = line_minus;
        end
    end

endmodule

// File: tb/tb_usb_bus_turnaround.sv
module tb_usb_bus_turnaround;

    typedef enum int { PH_RESET, PH_IDLE, PH_WAIT, PH_DRIVE, PH_HOLD, PH_TURN } ph_t;

    // Expected observation; pins carry a release flag (z*) plus a level (v*).
    typedef struct packed {
        logic grant;
        logic busy;
        logic rxv;
        logic rxp;
        logic rxm;
        logic zp;
        logic vp;
        logic zm;
        logic vm;
    } exp_t;

    logic clk;
    int   checks;
    int   failures;

    exp_t  q0[$];
    exp_t  q1[$];
    string n0[$];
    string n1[$];

    // DUT 0: full speed, defaults
    logic n_rst0, tx_req0, tx_p0, tx_m0;
    logic grant0, busy0, rxp0, rxm0, rxv0;
    logic ext_en0, ext_p0, ext_m0;
    wire  d_plus0, d_minus0;

    // DUT 1: low speed
    logic n_rst1, tx_req1, tx_p1, tx_m1;
    logic grant1, busy1, rxp1, rxm1, rxv1;
    logic ext_en1, ext_p1, ext_m1;
    wire  d_plus1, d_minus1;

    assign d_plus0  = ext_en0 ? ext_p0 : 1'bz;
    assign d_minus0 = ext_en0 ? ext_m0 : 1'bz;
    assign d_plus1  = ext_en1 ? ext_p1 : 1'bz;
    assign d_minus1 = ext_en1 ? ext_m1 : 1'bz;

    usb_bus_turnaround dut0 (
        .clk(clk), .n_rst(n_rst0), .tx_req(tx_req0),
        .tx_d_plus(tx_p0), .tx_d_minus(tx_m0),
        .tx_grant(grant0), .busy(busy0),
        .rx_d_plus(rxp0), .rx_d_minus(rxm0), .rx_valid(rxv0),
        .d_plus(d_plus0), .d_minus(d_minus0)
    );

    usb_bus_turnaround #(.LOW_SPEED(1'b1)) dut1 (
        .clk(clk), .n_rst(n_rst1), .tx_req(tx_req1),
        .tx_d_plus(tx_p1), .tx_d_minus(tx_m1),
        .tx_grant(grant1), .busy(busy1),
        .rx_d_plus(rxp1), .rx_d_minus(rxm1), .rx_valid(rxv1),
        .d_plus(d_plus1), .d_minus(d_minus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for a DUT in a given phase, given the bench's current
    // drive of tx data and the external line.
    function automatic exp_t model(input int d, input ph_t ph, input logic lp, input logic lm);
        exp_t e;
        logic jp, jm, tp, tm, ee, ep, em;
        jp = (d == 0) ? 1'b1 : 1'b0;
        jm = ~jp;
        tp = (d == 0) ? tx_p0 : tx_p1;
        tm = (d == 0) ? tx_m0 : tx_m1;
        ee = (d == 0) ? ext_en0 : ext_en1;
        ep = (d == 0) ? ext_p0 : ext_p1;
        em = (d == 0) ? ext_m0 : ext_m1;
        e.grant = (ph == PH_DRIVE);
        e.busy  = (ph == PH_WAIT) || (ph == PH_DRIVE) || (ph == PH_HOLD) || (ph == PH_TURN);
        e.rxv   = (ph == PH_IDLE);
        e.rxp   = (ph == PH_IDLE) ? lp : jp;
        e.rxm   = (ph == PH_IDLE) ? lm : jm;
        if (ph == PH_DRIVE)      {e.zp, e.vp, e.zm, e.vm} = {1'b0, tp, 1'b0, tm};
        else if (ph == PH_HOLD)  {e.zp, e.vp, e.zm, e.vm} = {1'b0, jp, 1'b0, jm};
        else if (ee)             {e.zp, e.vp, e.zm, e.vm} = {1'b0, ep, 1'b0, em};
        else                     {e.zp, e.vp, e.zm, e.vm} = 4'b1010;
        return e;
    endfunction

    task automatic push(input int d, input exp_t e, input string nm);
        if (d == 0) begin q0.push_back(e); n0.push_back(nm); end
        else        begin q1.push_back(e); n1.push_back(nm); end
    endtask

    // One clock: expectation for the state after the edge is queued, inputs
    // may be changed by the caller after the monitor's negedge sample.
    task automatic step(input int d, input ph_t ph, input logic lp, input logic lm, input string nm);
        @(posedge clk); #1;
        push(d, model(d, ph, lp, lm), nm);
        @(negedge clk); #1;
    endtask

    task automatic tick(input int d, input ph_t ph, input string nm);
        step(d, ph, (d == 0) ? 1'b1 : 1'b0, (d == 0) ? 1'b0 : 1'b1, nm);
    endtask

    // Reset asserted between edges; outputs must respond before the next edge.
    task automatic rst_mid(input int d, input string nm);
        @(posedge clk); #1;
        if (d == 0) n_rst0 = 1'b0; else n_rst1 = 1'b0;
        #1;
        push(d, model(d, PH_RESET, 1'b0, 1'b0), nm);
        @(negedge clk); #1;
    endtask

    // Drop tx_req and walk through hold, release and the blanked window,
    // optionally showing K on the line during blanking.
    task automatic packet_end(input int d, input bit inject_k);
        logic jp;
        jp = (d == 0) ? 1'b1 : 1'b0;
        if (d == 0) begin tx_req0 = 1'b0; tx_p0 = ~jp; tx_m0 = jp; end
        else        begin tx_req1 = 1'b0; tx_p1 = ~jp; tx_m1 = jp; end
        for (int i = 0; i < 8; i++) tick(d, PH_HOLD, "hold_j");
        tick(d, PH_TURN, "release");
        if (d == 0) begin ext_en0 = 1'b1; ext_p0 = inject_k ? ~jp : jp; ext_m0 = inject_k ? jp : ~jp; end
        else        begin ext_en1 = 1'b1; ext_p1 = inject_k ? ~jp : jp; ext_m1 = inject_k ? jp : ~jp; end
        for (int i = 1; i < 16; i++) begin
            if (i == 10) begin
                if (d == 0) begin ext_p0 = jp; ext_m0 = ~jp; end
                else        begin ext_p1 = jp; ext_m1 = ~jp; end
            end
            tick(d, PH_TURN, "turnaround");
        end
    endtask

    // A released pin must not read as 1 (undriven reads as z or 0).
    function automatic logic pin_ok(input logic a, input logic z, input logic v);
        return z ? (a !== 1'b1) : (a === v);
    endfunction

    function automatic string pstr(input logic z, input logic v);
        return z ? "Z" : (v ? "1" : "0");
    endfunction

    task automatic compare(input string nm, input logic g, input logic b, input logic v,
                           input logic rp, input logic rm, input logic pp, input logic pm,
                           input exp_t e);
        logic ok;
        ok = (g === e.grant) && (b === e.busy) && (v === e.rxv) &&
             (rp === e.rxp) && (rm === e.rxm) &&
             pin_ok(pp, e.zp, e.vp) && pin_ok(pm, e.zm, e.vm);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s @%0t: got grant=%b busy=%b rx_valid=%b rx=%b%b pins=%b%b, want grant=%b busy=%b rx_valid=%b rx=%b%b pins=%s%s",
                     nm, $time, g, b, v, rp, rm, pp, pm,
                     e.grant, e.busy, e.rxv, e.rxp, e.rxm, pstr(e.zp, e.vp), pstr(e.zm, e.vm));
        end
    endtask

    // Monitor: pops one expectation per cycle per DUT, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t  e;
        string nm;
        if (q0.size() != 0) begin
            e  = q0.pop_front();
            nm = n0.pop_front();
            compare({"dut0 ", nm}, grant0, busy0, rxv0, rxp0, rxm0, d_plus0, d_minus0, e);
        end
        if (q1.size() != 0) begin
            e  = q1.pop_front();
            nm = n1.pop_front();
            compare({"dut1 ", nm}, grant1, busy1, rxv1, rxp1, rxm1, d_plus1, d_minus1, e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        n_rst0 = 1'b0; tx_req0 = 1'b0; tx_p0 = 1'b1; tx_m0 = 1'b0;
        ext_en0 = 1'b1; ext_p0 = 1'b1; ext_m0 = 1'b0;
        n_rst1 = 1'b0; tx_req1 = 1'b0; tx_p1 = 1'b0; tx_m1 = 1'b1;
        ext_en1 = 1'b1; ext_p1 = 1'b0; ext_m1 = 1'b1;
        @(negedge clk); #1;

        // Reset state
        tick(0, PH_RESET, "reset");
        tick(1, PH_RESET, "reset");
        n_rst0 = 1'b1; n_rst1 = 1'b1;
        for (int i = 0; i < 3; i++) tick(0, PH_IDLE, "idle_after_reset");

        // Request with an idle line: two guard cycles, then grant
        tx_req0 = 1'b1;
        tick(0, PH_WAIT, "a_wait0");
        tick(0, PH_WAIT, "a_wait1");
        ext_en0 = 1'b0; tx_p0 = 1'b0; tx_m0 = 1'b1;
        tick(0, PH_DRIVE, "a_grant");
        for (int i = 1; i < 20; i++) begin
            {tx_p0, tx_m0} = 2'(i % 4);
            tick(0, PH_DRIVE, "a_drive");
        end
        packet_end(0, 1'b1);
        tick(0, PH_IDLE, "a_rx_back");
        tick(0, PH_IDLE, "a_idle");

        // Receive path passes K through the synchroniser with 2-cycle latency
        ext_p0 = 1'b0; ext_m0 = 1'b1;
        step(0, PH_IDLE, 1'b1, 1'b0, "sync_k0");
        step(0, PH_IDLE, 1'b0, 1'b1, "sync_k1");
        ext_p0 = 1'b1; ext_m0 = 1'b0;
        step(0, PH_IDLE, 1'b0, 1'b1, "sync_j0");
        step(0, PH_IDLE, 1'b1, 1'b0, "sync_j1");

        // K seen during the guard restarts the count
        ext_p0 = 1'b0; ext_m0 = 1'b1;
        tick(0, PH_IDLE, "b_pre");
        ext_p0 = 1'b1; ext_m0 = 1'b0; tx_req0 = 1'b1;
        tick(0, PH_WAIT, "b_wait0");
        tick(0, PH_WAIT, "b_k_seen");
        tick(0, PH_WAIT, "b_guard_restart");
        ext_en0 = 1'b0; tx_p0 = 1'b0; tx_m0 = 1'b0;
        tick(0, PH_DRIVE, "b_grant");
        tick(0, PH_DRIVE, "b_drive");
        packet_end(0, 1'b0);
        tick(0, PH_IDLE, "b_rx_back");
        tick(0, PH_IDLE, "b_idle");

        // Abort in the guard period
        tx_req0 = 1'b1;
        tick(0, PH_WAIT, "c_wait");
        tx_req0 = 1'b0;
        tick(0, PH_IDLE, "c_abort");
        tick(0, PH_IDLE, "c_idle");

        // Low speed: J is D+=0/D-=1
        tick(1, PH_IDLE, "d_idle");
        tx_req1 = 1'b1;
        tick(1, PH_WAIT, "d_wait0");
        tick(1, PH_WAIT, "d_wait1");
        ext_en1 = 1'b0; tx_p1 = 1'b1; tx_m1 = 1'b0;
        tick(1, PH_DRIVE, "d_grant");
        for (int i = 0; i < 4; i++) begin
            {tx_p1, tx_m1} = 2'(i);
            tick(1, PH_DRIVE, "d_drive");
        end
        packet_end(1, 1'b1);
        tick(1, PH_IDLE, "d_rx_back");
        tick(1, PH_IDLE, "d_idle2");

        // Reset in the middle of driving
        tx_req1 = 1'b1;
        tick(1, PH_WAIT, "e_wait0");
        tick(1, PH_WAIT, "e_wait1");
        ext_en1 = 1'b0; tx_p1 = 1'b1; tx_m1 = 1'b1;
        tick(1, PH_DRIVE, "e_grant");
        tick(1, PH_DRIVE, "e_drive");
        rst_mid(1, "e_reset_mid_drive");
        ext_en1 = 1'b1; tx_req1 = 1'b0;
        tick(1, PH_RESET, "e_in_reset");
        n_rst1 = 1'b1;
        tick(1, PH_IDLE, "e_after_reset");
        tick(1, PH_IDLE, "e_idle");

        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
